insn_sequencer: RTL and testbench

Multi-cycle control sequencer for the single-issue RISC-V core. It owns the PC and instruction register and steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It handshakes with instruction and data memory and generates register-file write enables and the retire count. It sits above the fetch/decode/execute datapath, consuming the opcode and rd fields produced by the decode stage and the branch decision and target produced by execute.

---
 rtl/insn_sequencer_if.sv | 40 ++++
 rtl/insn_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_insn_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/insn_sequencer_if.sv
// Memory-side handshake bundle of the instruction sequencer: the
// instruction-fetch port and the data-access port. The sequencer drives the
// requests (master); the memory system answers with ready/data (slave).
interface insn_sequencer_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);

  // Instruction fetch port
  logic              imem_req_o;
  logic [AWIDTH-1:0] imem_addr_o;
  logic              imem_ready_i;
  logic [DWIDTH-1:0] imem_rdata_i;

  // Data access port (address/data travel on the datapath, not here)
  logic              dmem_req_o;
  logic              dmem_we_o;
  logic              dmem_ready_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i,
    output dmem_req_o,
    output dmem_we_o,
    input  dmem_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i,
    input  dmem_req_o,
    input  dmem_we_o,
    output dmem_ready_i
  );

endinterface : insn_sequencer_if

// File: rtl/insn_sequencer.sv
// Multi-cycle control sequencer for the single-issue RISC-V core. Owns the PC
// and the instruction register and walks each instruction through
// FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB). All handshake and strobe
// outputs are registers loaded together with the state they belong to, so
// none of them depends combinationally on a memory ready input.
module insn_sequencer #(
  parameter int              AWIDTH   = 32,
  parameter int              DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst,
  insn_sequencer_if.master  mem,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic              branch_taken_i,
  input  logic [AWIDTH-1:0] target_i,
  output logic              rf_we_o,
  output logic [2:0]        state_o,
  output logic              retire_o,
  output logic [31:0]       instret_o,
  output logic              halted_o,
  output logic              fault_o
);

  // RV32I major opcodes the sequencer distinguishes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [DWIDTH-1:0] NOP_INSN = DWIDTH'(32'h0000_0013);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  // Path an instruction takes after EXECUTE, captured once in DECODE
  typedef enum logic [1:0] {
    CLS_WB     = 2'd0,   // ALU, JAL, JALR, LUI, AUIPC
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } insn_class_t;

  state_t            r_state;
  insn_class_t       r_class;
  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-1:0] r_next_pc;
  logic [DWIDTH-1:0] r_insn;
  logic [31:0]       r_instret;
  logic              r_imem_req;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic              r_rf_we;
  logic              r_retire;
  logic              r_halted;
  logic              r_fault;

  logic [AWIDTH-1:0] w_next_pc;
  logic              w_misaligned;

  // Redirect target or sequential successor; the add wraps at AWIDTH bits
  assign w_next_pc    = branch_taken_i ? target_i : r_pc + AWIDTH'(4);
  assign w_misaligned = branch_taken_i && (target_i[1:0] != 2'b00);

  // Sequencer FSM with its registered handshake and strobe outputs
  // NOTE: every register here uses <= so all of them see the same pre-edge
  // values; a blocking = would let later lines observe half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_class    <= CLS_WB;
      r_pc       <= RESET_PC;
      r_next_pc  <= RESET_PC;
      r_insn     <= NOP_INSN;
      r_instret  <= '0;
      r_imem_req <= 1'b1;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_retire   <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      // One-cycle strobes fall back to zero unless a transition raises them
      r_rf_we  <= 1'b0;
      r_retire <= 1'b0;

      case (r_state)
        S_FETCH: begin
          if (mem.imem_ready_i) begin
            r_insn     <= mem.imem_rdata_i;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode_i)
            OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
              r_class <= CLS_WB;
              r_state <= S_EXECUTE;
            end
            OPC_LOAD: begin
              r_class <= CLS_LOAD;
              r_state <= S_EXECUTE;
            end
            OPC_STORE: begin
              r_class <= CLS_STORE;
              r_state <= S_EXECUTE;
            end
            OPC_BRANCH: begin
              r_class <= CLS_BRANCH;
              r_state <= S_EXECUTE;
            end
            OPC_SYSTEM: begin
              // ECALL/EBREAK: orderly stop, not a fault
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            default: begin
              r_halted <= 1'b1;
              r_fault  <= 1'b1;
              r_state  <= S_HALT;
            end
          endcase
        end

        S_EXECUTE: begin
          r_next_pc <= w_next_pc;
          if (w_misaligned) begin
            // PC keeps pointing at the offending control-transfer instruction
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            case (r_class)
              CLS_LOAD, CLS_STORE: begin
                r_dmem_req <= 1'b1;
                r_dmem_we  <= (r_class == CLS_STORE);
                r_state    <= S_MEM;
              end
              CLS_BRANCH: begin
                // Retires straight from EXECUTE with the freshly computed PC
                r_pc       <= w_next_pc;
                r_instret  <= r_instret + 32'd1;
                r_retire   <= 1'b1;
                r_imem_req <= 1'b1;
                r_state    <= S_FETCH;
              end
              default: begin
                r_rf_we  <= (rd_i != 5'd0);
                r_retire <= 1'b1;
                r_state  <= S_WB;
              end
            endcase
          end
        end

        S_MEM: begin
          if (mem.dmem_ready_i) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (r_class == CLS_STORE) begin
              r_pc       <= r_next_pc;
              r_instret  <= r_instret + 32'd1;
              r_retire   <= 1'b1;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_rf_we  <= (rd_i != 5'd0);
              r_retire <= 1'b1;
              r_state  <= S_WB;
            end
          end
        end

        S_WB: begin
          // rf_we/retire were raised on entry; this edge commits the PC
          r_pc       <= r_next_pc;
          r_instret  <= r_instret + 32'd1;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

        default: begin
          // Unused encodings are treated as a fault rather than wandering
          r_halted <= 1'b1;
          r_fault  <= 1'b1;
          r_state  <= S_HALT;
        end
      endcase
    end
  end

  // Output wiring: everything visible outside is a register
  assign mem.imem_req_o  = r_imem_req;
  assign mem.imem_addr_o = r_pc;
  assign mem.dmem_req_o  = r_dmem_req;
  assign mem.dmem_we_o   = r_dmem_we;
  assign pc_o            = r_pc;
  assign insn_o          = r_insn;
  assign rf_we_o         = r_rf_we;
  assign state_o         = r_state;
  assign retire_o        = r_retire;
  assign instret_o       = r_instret;
  assign halted_o        = r_halted;
  assign fault_o         = r_fault;

endmodule : insn_sequencer

// File: tb/tb_insn_sequencer.sv
// Directed bench for insn_sequencer. The bench plays both memories and the
// decode stage (opcode/rd are sliced from insn_o); execute's branch decision
// is driven directly. Outputs are sampled 1 time unit after each rising edge.
module tb_insn_sequencer;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam logic [31:0] RPC = 32'h0100_0000;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;  // addi x1, x0, 5
  localparam logic [31:0] I_LW    = 32'h0000_A103;  // lw   x2, 0(x1)
  localparam logic [31:0] I_BEQ   = 32'h0000_0063;  // beq  x0, x0, ...
  localparam logic [31:0] I_ADD0  = 32'h0020_8033;  // add  x0, x1, x2
  localparam logic [31:0] I_SW    = 32'h0020_A023;  // sw   x2, 0(x1)
  localparam logic [31:0] I_ILL   = 32'h0000_007F;  // opcode 1111111
  localparam logic [31:0] I_ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, insn, target, instret;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        branch_taken, rf_we, retire, halted, fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  insn_sequencer_if #(.AWIDTH(AW), .DWIDTH(DW)) mem_if ();

  assign opcode = insn[6:0];
  assign rd     = insn[11:7];

  insn_sequencer #(.AWIDTH(AW), .DWIDTH(DW), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem            (mem_if),
    .pc_o           (pc),
    .insn_o         (insn),
    .opcode_i       (opcode),
    .rd_i           (rd),
    .branch_taken_i (branch_taken),
    .target_i       (target),
    .rf_we_o        (rf_we),
    .state_o        (state),
    .retire_o       (retire),
    .instret_o      (instret),
    .halted_o       (halted),
    .fault_o        (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; returns inside the first FETCH cycle
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  int n_req, n_we, n_ret, n_rf;

  initial begin
    rst                 = 1'b1;
    branch_taken        = 1'b0;
    target              = '0;
    mem_if.imem_ready_i = 1'b0;
    mem_if.imem_rdata_i = '0;
    mem_if.dmem_ready_i = 1'b0;

    // Reset values while rst is held
    #2;
    check("rst_state",   32'(state),           32'd0);
    check("rst_pc",      pc,                   RPC);
    check("rst_insn",    insn,                 32'h0000_0013);
    check("rst_instret", instret,              32'd0);
    check("rst_fault",   32'(fault),           32'd0);
    check("rst_halted",  32'(halted),          32'd0);
    check("rst_dreq",    32'(mem_if.dmem_req_o), 32'd0);
    check("rst_rfwe",    32'(rf_we),           32'd0);
    check("rst_retire",  32'(retire),          32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADDI at RESET_PC, zero-wait fetch: states 0,1,2,4
    check("t1_ireq",  32'(mem_if.imem_req_o), 32'd1);
    check("t1_iaddr", mem_if.imem_addr_o,     RPC);
    check("t1_s0",    32'(state),             32'd0);
    mem_if.imem_ready_i = 1'b1;
    mem_if.imem_rdata_i = I_ADDI;
    cyc();
    check("t1_s1",   32'(state), 32'd1);
    check("t1_insn", insn,       I_ADDI);
    cyc();
    check("t1_s2", 32'(state), 32'd2);
    cyc();
    check("t1_s4",     32'(state),  32'd4);
    check("t1_rfwe",   32'(rf_we),  32'd1);
    check("t1_retire", 32'(retire), 32'd1);
    cyc();
    check("t1_back",    32'(state),         32'd0);
    check("t1_instret", instret,            32'd1);
    check("t1_pc",      pc,                 32'h0100_0004);
    check("t1_iaddr2",  mem_if.imem_addr_o, 32'h0100_0004);
    check("t1_rfwe0",   32'(rf_we),         32'd0);

    // LW with dmem_ready delayed 3 cycles: 8 cycles total
    mem_if.imem_rdata_i = I_LW;
    n_req = 0; n_we = 0; n_ret = 0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_if.dmem_req_o) begin
        n_req++;
        if (mem_if.dmem_we_o) n_we++;
      end
      if (retire) n_ret++;
      if (k == 4) check("t2_mem", 32'(state), 32'd3);
      if (k == 8) begin
        check("t2_wb",   32'(state), 32'd4);
        check("t2_rfwe", 32'(rf_we), 32'd1);
      end
      mem_if.dmem_ready_i = (k == 7);
      cyc();
    end
    check("t2_back",    32'(state), 32'd0);
    check("t2_nreq",    32'(n_req), 32'd4);
    check("t2_nwe",     32'(n_we),  32'd0);
    check("t2_nret",    32'(n_ret), 32'd1);
    check("t2_pc",      pc,         32'h0100_0008);
    check("t2_instret", instret,    32'd2);

    // Taken BEQ to an aligned target; branch_taken held throughout
    mem_if.imem_rdata_i = I_BEQ;
    branch_taken = 1'b1;
    target       = 32'h0100_0040;
    n_ret = 0; n_rf = 0;
    for (int k = 1; k <= 3; k++) begin
      if (retire) n_ret++;
      if (rf_we)  n_rf++;
      cyc();
    end
    if (retire) n_ret++;
    check("t3_back",    32'(state),         32'd0);
    check("t3_iaddr",   mem_if.imem_addr_o, 32'h0100_0040);
    check("t3_instret", instret,            32'd3);
    check("t3_nrf",     32'(n_rf),          32'd0);
    check("t3_nret",    32'(n_ret),         32'd1);

    // Same BEQ, misaligned target -> fault, nothing retired
    target = 32'h0100_0042;
    cyc();
    cyc();
    cyc();
    check("t3f_state",   32'(state),             32'd5);
    check("t3f_fault",   32'(fault),             32'd1);
    check("t3f_halted",  32'(halted),            32'd1);
    check("t3f_instret", instret,                32'd3);
    check("t3f_pc",      pc,                     32'h0100_0040);
    check("t3f_ireq",    32'(mem_if.imem_req_o), 32'd0);
    check("t3f_retire",  32'(retire),            32'd0);
    branch_taken = 1'b0;
    cyc();
    cyc();
    check("t3f_stay",  32'(state),             32'd5);
    check("t3f_ireq2", 32'(mem_if.imem_req_o), 32'd0);

    // ADD with rd = x0: WB without a register write
    do_reset();
    check("t4_fault0", 32'(fault),  32'd0);
    check("t4_halt0",  32'(halted), 32'd0);
    mem_if.imem_rdata_i = I_ADD0;
    cyc();
    cyc();
    cyc();
    check("t4_wb",     32'(state),  32'd4);
    check("t4_rfwe",   32'(rf_we),  32'd0);
    check("t4_retire", 32'(retire), 32'd1);
    cyc();
    check("t4_instret", instret, 32'd1);
    check("t4_pc",      pc,      32'h0100_0004);

    // Illegal opcode -> fault after DECODE, no further fetches
    mem_if.imem_rdata_i = I_ILL;
    cyc();
    cyc();
    check("t5_state",  32'(state),             32'd5);
    check("t5_fault",  32'(fault),             32'd1);
    check("t5_halted", 32'(halted),            32'd1);
    check("t5_ireq",   32'(mem_if.imem_req_o), 32'd0);
    cyc();
    cyc();
    check("t5_ireq2",   32'(mem_if.imem_req_o), 32'd0);
    check("t5_instret", instret,                32'd1);

    // ECALL -> orderly halt
    do_reset();
    mem_if.imem_rdata_i = I_ECALL;
    cyc();
    cyc();
    check("t5e_state",   32'(state),  32'd5);
    check("t5e_halted",  32'(halted), 32'd1);
    check("t5e_fault",   32'(fault),  32'd0);
    check("t5e_instret", instret,     32'd0);

    // ADDI, zero-wait SW, then LW aborted by reset while in MEM
    do_reset();
    mem_if.imem_rdata_i = I_ADDI;
    cyc();
    cyc();
    cyc();
    cyc();
    check("t6_pc1", pc, 32'h0100_0004);
    mem_if.imem_rdata_i = I_SW;
    mem_if.dmem_ready_i = 1'b1;
    cyc();
    cyc();
    cyc();
    check("t6_sw_mem", 32'(state),             32'd3);
    check("t6_sw_req", 32'(mem_if.dmem_req_o), 32'd1);
    check("t6_sw_we",  32'(mem_if.dmem_we_o),  32'd1);
    cyc();
    check("t6_sw_back",    32'(state), 32'd0);
    check("t6_sw_pc",      pc,         32'h0100_0008);
    check("t6_sw_instret", instret,    32'd2);
    mem_if.dmem_ready_i = 1'b0;
    mem_if.imem_rdata_i = I_LW;
    cyc();
    cyc();
    cyc();
    check("t6_lw_req", 32'(mem_if.dmem_req_o), 32'd1);
    check("t6_lw_we",  32'(mem_if.dmem_we_o),  32'd0);
    cyc();
    check("t6_lw_wait", 32'(state), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_abort_req",     32'(mem_if.dmem_req_o), 32'd0);
    check("t6_abort_state",   32'(state),             32'd0);
    check("t6_abort_pc",      pc,                     RPC);
    check("t6_abort_instret", instret,                32'd0);
    check("t6_abort_rfwe",    32'(rf_we),             32'd0);
    check("t6_abort_retire",  32'(retire),            32'd0);
    cyc();
    rst = 1'b0;
    mem_if.imem_ready_i = 1'b0;
    cyc();
    check("t6_ireq", 32'(mem_if.imem_req_o), 32'd1);
    check("t6_rfwe", 32'(rf_we),             32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_insn_sequencer
